// File: rtl/game_pkg.sv
// Shared types and helpers for the frame scheduler: phase codes, FSM state, sizing functions.
// Latency: n/a (package only).
// Backpressure: n/a.
package game_pkg;

    // Values driven on the phase output
    localparam logic [1:0] PH_IDLE = 2'd0;
    localparam logic [1:0] PH_MOVE = 2'd1;
    localparam logic [1:0] PH_PAIR = 2'd2;
    localparam logic [1:0] PH_DONE = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MOVE,
        ST_PAIR,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Ceiling log2; clog2(1) = 0
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Number of unordered pairs among n objects
    function automatic int npairs(input int n);
        return (n * (n - 1)) / 2;
    endfunction

endpackage

// File: rtl/game_pair_walker.sv
// Pair walker: holds the next pair (a,b) and its linear index p in lexicographic order.
// Latency: clear/step take effect on the next clock edge.
// Backpressure: none; advances only when step_i is high and saturates on the last pair.
// Ports: clk, rst_n; clear_i rewinds to (0,1,p=0); step_i advances;
//        a_o/b_o/p_o the current pair; last_o flags the final pair (N-2,N-1).
module game_pair_walker #(
    parameter int N     = 8,
    parameter int IDX_W = 3,
    parameter int NP    = 28,
    parameter int PW    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             step_i,
    output logic [IDX_W-1:0] a_o,
    output logic [IDX_W-1:0] b_o,
    output logic [PW-1:0]    p_o,
    output logic             last_o
);

    logic [IDX_W-1:0] a_q, a_d;
    logic [IDX_W-1:0] b_q, b_d;
    logic [PW-1:0]    p_q, p_d;
    logic             last;

    assign last = (p_q == PW'(NP - 1));

    always_comb begin
        a_d = a_q;
        b_d = b_q;
        p_d = p_q;
        if (clear_i) begin
            a_d = '0;
            b_d = IDX_W'(1);
            p_d = '0;
        end else if (step_i && !last) begin
            // Row wrap: b hit the top, start the next row at (a+1, a+2).
            // Never reached from the last pair, so a+2 cannot overflow.
            if (b_q == IDX_W'(N - 1)) begin
                a_d = a_q + IDX_W'(1);
                b_d = a_q + IDX_W'(2);
            end else begin
                b_d = b_q + IDX_W'(1);
            end
            p_d = p_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= IDX_W'(1);
            p_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            p_q <= p_d;
        end
    end

    assign a_o    = a_q;
    assign b_o    = b_q;
    assign p_o    = p_q;
    assign last_o = last;

endmodule

// File: rtl/game_frame_scheduler.sv
// Per-frame sequencer: MOVE one object/cycle, PAIR one pair/cycle, then DRAIN and DONE; owns pair cooldowns.
// Latency: schedule is N+NP+2 cycles after frame_tick; hit_valid follows its pair_valid by 1 cycle.
// Backpressure: none; a frame_tick while busy is dropped and flagged with a one-cycle overrun.
// Ports: clk, rst_n; frame_tick starts a schedule; busy/phase report progress;
//        move_valid/move_idx and pair_valid/pair_a/pair_b drive the datapath; overlap_in is the
//        comparator result; hit_valid/hit_a/hit_b qualified hits; frame_done end pulse; overrun dropped tick.
module game_frame_scheduler
    import game_pkg::*;
#(
    parameter int N         = 8,
    parameter int CD_FRAMES = 5,
    parameter int CD_W      = 4,
    localparam int IDX_W    = clog2(N),
    localparam int NP       = npairs(N),
    localparam int PW       = clog2(NP)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_tick,
    output logic             busy,
    output logic [1:0]       phase,
    output logic             move_valid,
    output logic [IDX_W-1:0] move_idx,
    output logic             pair_valid,
    output logic [IDX_W-1:0] pair_a,
    output logic [IDX_W-1:0] pair_b,
    input  logic             overlap_in,
    output logic             hit_valid,
    output logic [IDX_W-1:0] hit_a,
    output logic [IDX_W-1:0] hit_b,
    output logic             frame_done,
    output logic             overrun
);

    // A single pair still needs a 1-bit index
    localparam int PW_S = (PW < 1) ? 1 : PW;

    state_t           state_q;
    logic             busy_q, move_valid_q, pair_valid_q, frame_done_q, overrun_q;
    logic [1:0]       phase_q;
    logic [IDX_W-1:0] move_idx_q, pair_a_q, pair_b_q;
    logic [PW_S-1:0]  pair_p_q;
    logic             pair_last_q;

    // Pair issued last cycle, waiting for its overlap_in
    logic             pend_vld_q;
    logic [IDX_W-1:0] pend_a_q, pend_b_q;
    logic [PW_S-1:0]  pend_p_q;

    logic [CD_W-1:0]  cd_q [NP];
    logic [CD_W-1:0]  cd_rd, cd_d;
    logic             hit;

    logic [IDX_W-1:0] w_a, w_b;
    logic [PW_S-1:0]  w_p;
    logic             w_last, w_clr, w_step, move_last;

    assign move_last = (move_idx_q == IDX_W'(N - 1));
    assign w_clr     = (state_q == ST_IDLE);
    // The walker holds the next pair to issue; advance it each time one goes out
    assign w_step    = ((state_q == ST_MOVE) && move_last) ||
                       ((state_q == ST_PAIR) && !pair_last_q);

    game_pair_walker #(
        .N     (N),
        .IDX_W (IDX_W),
        .NP    (NP),
        .PW    (PW_S)
    ) u_walker (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (w_clr),
        .step_i  (w_step),
        .a_o     (w_a),
        .b_o     (w_b),
        .p_o     (w_p),
        .last_o  (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            phase_q      <= PH_IDLE;
            move_valid_q <= 1'b0;
            move_idx_q   <= '0;
            pair_valid_q <= 1'b0;
            pair_a_q     <= '0;
            pair_b_q     <= '0;
            pair_p_q     <= '0;
            pair_last_q  <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            overrun_q    <= frame_tick && busy_q;
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (frame_tick) begin
                        state_q      <= ST_MOVE;
                        busy_q       <= 1'b1;
                        phase_q      <= PH_MOVE;
                        move_valid_q <= 1'b1;
                        move_idx_q   <= '0;
                    end
                end
                ST_MOVE: begin
                    if (move_last) begin
                        state_q      <= ST_PAIR;
                        phase_q      <= PH_PAIR;
                        move_valid_q <= 1'b0;
                        pair_valid_q <= 1'b1;
                        pair_a_q     <= w_a;
                        pair_b_q     <= w_b;
                        pair_p_q     <= w_p;
                        pair_last_q  <= w_last;
                    end else begin
                        move_idx_q <= move_idx_q + IDX_W'(1);
                    end
                end
                ST_PAIR: begin
                    if (pair_last_q) begin
                        state_q      <= ST_DRAIN;
                        phase_q      <= PH_DONE;
                        pair_valid_q <= 1'b0;
                    end else begin
                        pair_a_q    <= w_a;
                        pair_b_q    <= w_b;
                        pair_p_q    <= w_p;
                        pair_last_q <= w_last;
                    end
                end
                ST_DRAIN: begin
                    state_q      <= ST_DONE;
                    frame_done_q <= 1'b1;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    phase_q <= PH_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld_q <= 1'b0;
            pend_a_q   <= '0;
            pend_b_q   <= '0;
            pend_p_q   <= '0;
        end else begin
            pend_vld_q <= pair_valid_q;
            pend_a_q   <= pair_a_q;
            pend_b_q   <= pair_b_q;
            pend_p_q   <= pair_p_q;
        end
    end

    // Cooldown read port: compare-select avoids an index wider than the array
    always_comb begin
        cd_rd = '0;
        for (int i = 0; i < NP; i++) begin
            if (pend_p_q == PW_S'(i)) cd_rd = cd_q[i];
        end
    end

    // overlap_in only matters in the cycle after a pair was issued
    assign hit  = pend_vld_q && overlap_in && (cd_rd == '0);
    assign cd_d = hit             ? CD_W'(CD_FRAMES) :
                  (cd_rd != '0)   ? cd_rd - CD_W'(1) : cd_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NP; i++) cd_q[i] <= '0;
        end else begin
            for (int i = 0; i < NP; i++) begin
                if (pend_vld_q && (pend_p_q == PW_S'(i))) cd_q[i] <= cd_d;
            end
        end
    end

    assign busy       = busy_q;
    assign phase      = phase_q;
    assign move_valid = move_valid_q;
    assign move_idx   = move_idx_q;
    assign pair_valid = pair_valid_q;
    assign pair_a     = pair_a_q;
    assign pair_b     = pair_b_q;
    assign hit_valid  = hit;
    assign hit_a      = pend_a_q;
    assign hit_b      = pend_b_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_game_frame_scheduler.sv
// Directed bench for game_frame_scheduler (N=8 main instance, N=2 secondary instance).
// Latency: n/a.
// Backpressure: n/a.
module tb_game_frame_scheduler;

    localparam int N  = 8;
    localparam int NP = 28;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, frame_tick, overlap_in;
    logic       busy, move_valid, pair_valid, hit_valid, frame_done, overrun;
    logic [1:0] phase;
    logic [2:0] move_idx, pair_a, pair_b, hit_a, hit_b;

    logic       tick2, ov2;
    logic       busy2, mv2, pv2, hv2, fd2, ovr2;
    logic [1:0] phase2;
    logic [0:0] midx2, pa2, pb2, ha2, hb2;

    game_frame_scheduler #(.N(8), .CD_FRAMES(5), .CD_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .busy       (busy),
        .phase      (phase),
        .move_valid (move_valid),
        .move_idx   (move_idx),
        .pair_valid (pair_valid),
        .pair_a     (pair_a),
        .pair_b     (pair_b),
        .overlap_in (overlap_in),
        .hit_valid  (hit_valid),
        .hit_a      (hit_a),
        .hit_b      (hit_b),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    game_frame_scheduler #(.N(2), .CD_FRAMES(5), .CD_W(4)) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (tick2),
        .busy       (busy2),
        .phase      (phase2),
        .move_valid (mv2),
        .move_idx   (midx2),
        .pair_valid (pv2),
        .pair_a     (pa2),
        .pair_b     (pb2),
        .overlap_in (ov2),
        .hit_valid  (hv2),
        .hit_a      (ha2),
        .hit_b      (hb2),
        .frame_done (fd2),
        .overrun    (ovr2)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Per-frame observations
    int r_hits, r_first, r_last, r_dones, r_done_at, r_ovr, r_busy;
    int r_seq_err, r_hit_mv, r_hit_a, r_hit_b, r_zero;

    // Runs one frame; sample c is taken 1 time unit after the c-th edge following the tick edge.
    // mode 0: no overlaps, 1: only pair (ha,hb) overlaps, 2: every pair overlaps.
    // t1/t2: cycles in which an extra frame_tick is driven; rst_at: cycle to assert reset (-1 none).
    task automatic run_frame(input int mode, input int ha, input int hb,
                             input int t1, input int t2, input int rst_at);
        int   ea, eb, pp_a, pp_b, exp_ph;
        logic pp_v;
        ea = 0; eb = 1; pp_v = 1'b0; pp_a = 0; pp_b = 0;
        r_hits = 0; r_first = -1; r_last = -1; r_dones = 0; r_done_at = -1;
        r_ovr = 0; r_busy = 0; r_seq_err = 0; r_hit_mv = 0; r_hit_a = -1; r_hit_b = -1; r_zero = -1;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        for (int c = 0; c < 46; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            if (c == rst_at) begin
                rst_n = 1'b0;
                #1;
                r_zero = int'(busy) + int'(phase) + int'(move_valid) + int'(move_idx) +
                         int'(pair_valid) + int'(pair_a) + int'(pair_b) + int'(hit_valid) +
                         int'(hit_a) + int'(hit_b) + int'(frame_done) + int'(overrun);
                break;
            end
            frame_tick = (c == t1) || (c == t2);
            if (move_valid != (c < N)) r_seq_err++;
            if ((c < N) && (int'(move_idx) != c)) r_seq_err++;
            if (pair_valid != ((c >= N) && (c < N + NP))) r_seq_err++;
            if (pair_valid && (c >= N) && (c < N + NP)) begin
                if ((int'(pair_a) != ea) || (int'(pair_b) != eb)) r_seq_err++;
                if (eb == N - 1) begin
                    ea = ea + 1;
                    eb = ea + 1;
                end else begin
                    eb = eb + 1;
                end
            end
            if (move_valid && pair_valid) r_seq_err++;
            if (busy != (c <= N + NP + 1)) r_seq_err++;
            exp_ph = (c < N) ? 1 : (c < N + NP) ? 2 : (c <= N + NP + 1) ? 3 : 0;
            if (int'(phase) != exp_ph) r_seq_err++;
            if (busy) r_busy++;
            if (frame_done) begin
                r_dones++;
                r_done_at = c;
            end
            if (overrun) r_ovr++;
            // Comparator model: answer for the pair shown in the previous cycle
            overlap_in = pp_v && ((mode == 2) || ((mode == 1) && (pp_a == ha) && (pp_b == hb)));
            pp_v = pair_valid;
            pp_a = int'(pair_a);
            pp_b = int'(pair_b);
            #1;
            if (hit_valid) begin
                r_hits++;
                if (r_first < 0) r_first = c;
                r_last  = c;
                r_hit_a = int'(hit_a);
                r_hit_b = int'(hit_b);
                if (move_valid) r_hit_mv++;
            end
        end
        frame_tick = 1'b0;
        overlap_in = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    int hit_mask;
    int err2, busy2_cnt, exp_ph2;

    initial begin
        rst_n = 1'b0; frame_tick = 1'b0; overlap_in = 1'b0; tick2 = 1'b0; ov2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",     int'(busy), 0);
        check("rst_phase",    int'(phase), 0);
        check("rst_outs",     int'(move_valid) + int'(pair_valid) + int'(hit_valid) +
                              int'(frame_done) + int'(overrun) + int'(move_idx) +
                              int'(pair_a) + int'(pair_b) + int'(hit_a) + int'(hit_b), 0);
        check("rst_outs_n2",  int'(busy2) + int'(phase2) + int'(mv2) + int'(pv2) + int'(hv2) +
                              int'(fd2) + int'(ovr2) + int'(midx2) + int'(pa2) + int'(pb2) +
                              int'(ha2) + int'(hb2), 0);
        rst_n = 1'b1;

        // Plain frame, no overlaps
        run_frame(0, 0, 0, -1, -1, -1);
        check("f0_sequence",  r_seq_err, 0);
        check("f0_hits",      r_hits, 0);
        check("f0_done_cnt",  r_dones, 1);
        check("f0_done_at",   r_done_at, 37);
        check("f0_busy_len",  r_busy, 38);

        // Only (2,5) overlaps, frames 1..7: hits in frames 1 and 7
        do_reset();
        hit_mask = 0;
        for (int f = 1; f <= 7; f++) begin
            run_frame(1, 2, 5, -1, -1, -1);
            if (r_hits > 0) hit_mask = hit_mask | (1 << f);
            if (f == 1) begin
                check("cd_hit_a", r_hit_a, 2);
                check("cd_hit_b", r_hit_b, 5);
                check("cd_hit_cnt", r_hits, 1);
            end
        end
        check("cd_frame_mask", hit_mask, 130);

        // Every pair overlaps
        do_reset();
        run_frame(2, 0, 0, -1, -1, -1);
        check("all_hits",     r_hits, 28);
        check("all_first",    r_first, 9);
        check("all_last",     r_last, 36);
        check("all_last_a",   r_hit_a, 6);
        check("all_last_b",   r_hit_b, 7);
        check("all_no_mv",    r_hit_mv, 0);
        check("all_sequence", r_seq_err, 0);

        // Ticks mid-PAIR and in DONE are dropped
        do_reset();
        run_frame(0, 0, 0, 20, 37, -1);
        check("ovr_count",    r_ovr, 2);
        check("ovr_dones",    r_dones, 1);
        check("ovr_sequence", r_seq_err, 0);

        // Reset at pair (1,3) after a hit on (0,1)
        do_reset();
        run_frame(1, 0, 1, -1, -1, 16);
        check("rst_mid_hits", r_hits, 1);
        check("rst_mid_zero", r_zero, 0);
        check("rst_mid_done", r_dones, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold", int'(frame_done) + int'(busy), 0);
        rst_n = 1'b1;
        run_frame(1, 0, 1, -1, -1, -1);
        check("post_rst_hits", r_hits, 1);
        check("post_rst_a",    r_hit_a, 0);
        check("post_rst_b",    r_hit_b, 1);

        // N=2 build: 2 moves, 1 pair, frame_done 5 cycles in
        err2 = 0; busy2_cnt = 0;
        tick2 = 1'b1;
        @(posedge clk); #1;
        tick2 = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            if (mv2 != (c < 2)) err2++;
            if ((c < 2) && (int'(midx2) != c)) err2++;
            if (pv2 != (c == 2)) err2++;
            if ((c == 2) && ((int'(pa2) != 0) || (int'(pb2) != 1))) err2++;
            if (fd2 != (c == 4)) err2++;
            exp_ph2 = (c < 2) ? 1 : (c == 2) ? 2 : (c <= 4) ? 3 : 0;
            if (int'(phase2) != exp_ph2) err2++;
            if (hv2 || ovr2) err2++;
            if (busy2) busy2_cnt++;
        end
        check("n2_sequence", err2, 0);
        check("n2_busy_len", busy2_cnt, 5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
